// File: rtl/sr_latch_monitor.sv
// sr_latch_monitor
//   Watches an SR latch from the outside. The s/r commands driven to the latch
//   and the latch outputs q/q_bar are registered once. A reference model FSM
//   predicts q from the sampled commands, and a settle timer holds off checking
//   after each new hold command. Sticky error flags and saturating event
//   counters summarise what was seen.
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   s, r          commands driven to the observed latch
//   q, q_bar      observed latch outputs
//   clr           synchronous clear of counters and sticky flags
//   exp_q         model's expected q
//   exp_valid     model state is defined (HOLD0/HOLD1)
//   set_cnt       set commands seen (rising edges of s&~r)
//   rst_cnt       reset commands seen (rising edges of r&~s)
//   err_cnt       cycles with at least one error
//   err_mismatch  sticky: q differed from exp_q while checking
//   err_comp      sticky: q_bar was not the complement of q while checking
//   err_invalid   sticky: s and r were both high
//
// Model FSM states
//   state | meaning
//   UNK   | latch content unknown (after reset or after leaving INV)
//   HOLD0 | latch holds 0
//   HOLD1 | latch holds 1
//   INV   | s and r both asserted, outputs undefined

module sr_latch_monitor #(
    parameter int CNT_W  = 8,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             q_bar,
    input  logic             clr,
    output logic             exp_q,
    output logic             exp_valid,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] rst_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_mismatch,
    output logic             err_comp,
    output logic             err_invalid
);

    typedef enum logic [1:0] {
        ST_UNK   = 2'd0,
        ST_HOLD0 = 2'd1,
        ST_HOLD1 = 2'd2,
        ST_INV   = 2'd3
    } state_t;

    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Sample stage
    logic s_q, r_q, q_q, q_bar_q;
    logic set_prev, rst_prev;

    state_t     state_q, state_d;
    logic [3:0] settle_q;

    logic set_cond, rst_cond;
    logic set_edge, rst_edge;
    logic settle_load;
    logic chk_en;
    logic hit_mismatch, hit_comp, hit_invalid, hit_any;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            q_q      <= 1'b0;
            q_bar_q  <= 1'b0;
            set_prev <= 1'b0;
            rst_prev <= 1'b0;
        end else begin
            s_q      <= s;
            r_q      <= r;
            q_q      <= q;
            q_bar_q  <= q_bar;
            set_prev <= set_cond;
            rst_prev <= rst_cond;
        end
    end

    assign set_cond = s_q & ~r_q;
    assign rst_cond = r_q & ~s_q;
    assign set_edge = set_cond & ~set_prev;
    assign rst_edge = rst_cond & ~rst_prev;

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_UNK;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case ({s_q, r_q})
            2'b10:   state_d = ST_HOLD1;
            2'b01:   state_d = ST_HOLD0;
            2'b11:   state_d = ST_INV;
            default: state_d = (state_q == ST_INV) ? ST_UNK : state_q;
        endcase
    end

    // FSM: outputs
    always_comb begin
        exp_q     = 1'b0;
        exp_valid = 1'b0;
        unique case (state_q)
            ST_HOLD0: exp_valid = 1'b1;
            ST_HOLD1: begin
                exp_valid = 1'b1;
                exp_q     = 1'b1;
            end
            default: ;
        endcase
    end

    // Re-arm the settle timer on entry into a hold state, and also on a fresh
    // command that lands in the state already held (e.g. 10, 00, 10).
    assign settle_load = ((state_d == ST_HOLD1) && ((state_q != ST_HOLD1) || set_edge)) ||
                         ((state_d == ST_HOLD0) && ((state_q != ST_HOLD0) || rst_edge));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            settle_q <= 4'd0;
        end else if (settle_load) begin
            settle_q <= SETTLE_LD;
        end else if (settle_q != 4'd0) begin
            settle_q <= settle_q - 4'd1;
        end
    end

    assign chk_en       = exp_valid && (settle_q == 4'd0);
    assign hit_mismatch = chk_en && (q_q != exp_q);
    assign hit_comp     = chk_en && (q_bar_q != ~q_q);
    assign hit_invalid  = s_q & r_q;
    assign hit_any      = hit_mismatch | hit_comp | hit_invalid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            set_cnt      <= '0;
            rst_cnt      <= '0;
            err_cnt      <= '0;
            err_mismatch <= 1'b0;
            err_comp     <= 1'b0;
            err_invalid  <= 1'b0;
        end else if (clr) begin
            set_cnt      <= '0;
            rst_cnt      <= '0;
            err_cnt      <= '0;
            err_mismatch <= 1'b0;
            err_comp     <= 1'b0;
            err_invalid  <= 1'b0;
        end else begin
            if (set_edge && (set_cnt != CNT_MAX)) begin
                set_cnt <= set_cnt + CNT_ONE;
            end
            if (rst_edge && (rst_cnt != CNT_MAX)) begin
                rst_cnt <= rst_cnt + CNT_ONE;
            end
            if (hit_any && (err_cnt != CNT_MAX)) begin
                err_cnt <= err_cnt + CNT_ONE;
            end
            err_mismatch <= err_mismatch | hit_mismatch;
            err_comp     <= err_comp | hit_comp;
            err_invalid  <= err_invalid | hit_invalid;
        end
    end

endmodule

// File: doc/sr_latch_monitor.md
SR_LATCH_MONITOR -- requirements
Module: sr_latch_monitor

Interface
REQ-001 Parameter CNT_W, default 8, width of every event/error counter.
REQ-002 Parameter SETTLE, default 2, cycles allowed for q/q_bar to follow a new command before checking (range 0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 s  input  1  set command driven to the latch under observation.
REQ-006 r  input  1  reset command driven to the latch under observation.
REQ-007 q  input  1  latch output under observation.
REQ-008 q_bar  input  1  latch complementary output under observation.
REQ-009 clr  input  1  synchronous clear of counters and sticky flags.
REQ-010 exp_q  output  1  model's expected q.
REQ-011 exp_valid  output  1  high when the model state is defined (HOLD0/HOLD1).
REQ-012 set_cnt  output  CNT_W  number of set commands seen.
REQ-013 rst_cnt  output  CNT_W  number of reset commands seen.
REQ-014 err_cnt  output  CNT_W  number of cycles with at least one error.
REQ-015 err_mismatch, err_comp, err_invalid  output  1 each  sticky error flags.

Function
REQ-016 s, r, q, q_bar SHALL be registered once (sample stage); all logic below uses the sampled values only.
REQ-017 Model FSM states UNK, HOLD0, HOLD1, INV, encoded in 2 bits; updated one edge after sampling (2-cycle input-to-exp_q latency).
REQ-018 Transitions from any state on sampled (s,r): 10 -> HOLD1; 01 -> HOLD0; 11 -> INV; 00 -> stay, except INV with 00 -> UNK.
REQ-019 exp_valid SHALL be 1 in HOLD0/HOLD1, else 0; exp_q SHALL be 1 only in HOLD1.
REQ-020 A settle counter SHALL load SETTLE on every FSM transition into HOLD0 or HOLD1 (including HOLD1->HOLD1 re-entry from a new 10 command after 00), decrement to 0, and hold at 0.
REQ-021 Checks are enabled only when exp_valid=1 and settle counter = 0; with SETTLE=0 checking starts the cycle after entry.
REQ-022 Mismatch: enabled and sampled q != exp_q -> err_mismatch set.
REQ-023 Complement: enabled and sampled q_bar != ~q -> err_comp set.
REQ-024 Invalid: sampled s=1 and r=1 -> err_invalid set (no enable required).
REQ-025 set_cnt SHALL increment once per rising edge of the sampled (s&~r) condition; rst_cnt likewise for (r&~s); a held command counts once.
REQ-026 err_cnt SHALL increment by exactly 1 in any cycle where one or more of REQ-022..024 fire, regardless of how many fire.
REQ-027 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 clr=1 SHALL zero all counters and sticky flags at the next edge; clr wins over a same-cycle increment or flag set; clr SHALL NOT affect FSM, settle counter, or sample stage.
REQ-029 Sticky flags SHALL remain set until clr or reset.

Reset
REQ-030 reset_n=0 SHALL immediately force FSM=UNK, settle counter=0, sample registers=0, all counters=0, all flags=0, exp_q=0, exp_valid=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight samples; the first command after release is treated as a fresh edge for set_cnt/rst_cnt.

Verification
REQ-032 Reset then s=1,r=0 for 1 cycle with a correct latch (q=1,q_bar=0 after 1 cycle) -> exp_q=1, exp_valid=1 two cycles later, set_cnt=1, no flags, err_cnt=0.
REQ-033 Sequence set, hold, reset, hold, set (with 00 between, as in the latch bench) against a correct latch -> set_cnt=2, rst_cnt=1, exp_q ends 1, err_cnt=0.
REQ-034 Latch model stuck at q=0 while s pulses, SETTLE=2 -> err_mismatch=1 starting 3 cycles after FSM enters HOLD1, err_cnt = number of stuck cycles after settle.
REQ-035 s=r=1 for 3 cycles then 00 -> err_invalid=1, err_cnt=3, FSM INV then UNK, exp_valid=0.
REQ-036 Force q=q_bar=1 in HOLD1, and drive >255 error cycles with CNT_W=8 -> err_comp=1, err_cnt saturates at 255; then clr for 1 cycle -> all counters/flags 0, exp_q still 1.
REQ-037 Assert reset_n=0 asynchronously between edges mid-HOLD1 -> all outputs 0 before next edge; after release, a held s=1 counts set_cnt=1.
